// File: rtl/func_sweep_ctrl.sv
// Sweep sequencer/checker for the function unit F = AC + ABC' + BD + A'C'D'.
// Drives all 16 {A,B,C,D} vectors, samples F after a settle time and compares against EXP_TT.
module func_sweep_ctrl #(
  parameter logic [15:0] EXP_TT     = 16'hFCB1,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  abcd_o,
  input  logic        f_i,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_cnt,
  output logic [3:0]  first_err_idx,
  output logic [15:0] captured
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  localparam logic [3:0] WCNT_LAST = 4'(SETTLE_CYC - 1);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [3:0]  r_wcnt;
  logic [3:0]  r_abcd;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [4:0]  r_err;
  logic [3:0]  r_first;
  logic [15:0] r_cap;

  logic        w_mis;
  logic [4:0]  w_err_nxt;

  assign w_mis     = f_i ^ EXP_TT[r_idx];
  assign w_err_nxt = r_err + 5'(w_mis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wcnt  <= '0;
      r_abcd  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
      r_cap   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= '0;
            r_abcd  <= '0;
            r_wcnt  <= '0;
            r_busy  <= 1'b1;
            r_cap   <= '0;
            r_err   <= '0;
            r_first <= '0;
            r_pass  <= 1'b0;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_wcnt == WCNT_LAST) begin
            r_state <= S_SAMPLE;
          end else begin
            r_wcnt <= r_wcnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          r_cap[r_idx] <= f_i;
          if (w_mis) begin
            r_err <= w_err_nxt;
            if (r_err == '0) r_first <= r_idx;
          end
          // pass uses the post-sample error count so the last vector is included
          if (r_idx == 4'd15) begin
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_abcd  <= r_idx + 4'd1;
            r_wcnt  <= '0;
            r_state <= S_SETTLE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_abcd  <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign abcd_o        = r_abcd;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_cnt       = r_err;
  assign first_err_idx = r_first;
  assign captured      = r_cap;

endmodule

// File: tb/tb_func_sweep_ctrl.sv
// Bench for func_sweep_ctrl: behavioural function-unit model driven from abcd_o,
// table of fault patterns plus hand-written reset, ignored-start and back-to-back sequences.
module tb_func_sweep_ctrl;

  localparam int LAT = 48;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  abcd_o;
  logic        f_i;
  logic        busy, done, pass;
  logic [4:0]  err_cnt;
  logic [3:0]  first_err_idx;
  logic [15:0] captured;

  logic [15:0] unit_tt = 16'h0000;
  logic        unit_dly = 1'b0;
  logic [3:0]  r_dly_abcd = 4'h0;

  int n_pass = 0;
  int n_total = 0;

  func_sweep_ctrl #(.EXP_TT(16'hFCB1), .SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abcd_o(abcd_o), .f_i(f_i),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .captured(captured)
  );

  always #5 clk = ~clk;

  always @(posedge clk) r_dly_abcd <= abcd_o;
  always_comb f_i = unit_dly ? unit_tt[r_dly_abcd] : unit_tt[abcd_o];

  function automatic logic f_eq(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (a & c) | (a & b & ~c) | (b & d) | (~a & ~c & ~d);
  endfunction

  function automatic logic [15:0] good_tt();
    logic [15:0] t;
    for (int i = 0; i < 16; i++) t[i] = f_eq(4'(i));
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] tt;
    logic [15:0] cap;
    logic [4:0]  err;
    logic [3:0]  first;
    logic        pas;
  } vec_t;

  vec_t vecs[8];

  task automatic sweep(input string tag, input bit mid_pulse,
                       input logic [15:0] e_cap, input logic [4:0] e_err,
                       input logic [3:0] e_first, input logic e_pass);
    int lat;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk({tag, " busy_on_accept"}, 32'(busy), 32'd1);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (mid_pulse && lat == 20) start = 1'b1;
      if (mid_pulse && lat == 21) start = 1'b0;
    end
    chk({tag, " done_latency"}, 32'(lat), 32'(LAT));
    chk({tag, " captured"}, 32'(captured), 32'(e_cap));
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'(e_err));
    if (e_err != 0) chk({tag, " first_err_idx"}, 32'(first_err_idx), 32'(e_first));
    chk({tag, " pass"}, 32'(pass), 32'(e_pass));
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " busy_drop"}, 32'(busy), 32'd0);
    chk({tag, " abcd_idle"}, 32'(abcd_o), 32'd0);
    chk({tag, " results_held"}, 32'({pass, err_cnt, captured}), 32'({e_pass, e_err, e_cap}));
  endtask

  initial begin
    logic [15:0] g, m;
    int bit_i;
    g = good_tt();

    vecs[0] = '{g,            16'hFCB1, 5'd0,  4'd0,  1'b1};
    vecs[1] = '{16'h0000,     16'h0000, 5'd10, 4'd0,  1'b0};
    vecs[2] = '{16'hFFFF,     16'hFFFF, 5'd6,  4'd1,  1'b0};
    vecs[3] = '{g ^ 16'h1000, 16'hECB1, 5'd1,  4'd12, 1'b0};
    for (int k = 4; k < 8; k++) begin
      m = 16'($urandom_range(1, 16'hFFFF));
      vecs[k].tt    = g ^ m;
      vecs[k].cap   = g ^ m;
      vecs[k].err   = 5'($countones(m));
      vecs[k].pas   = 1'b0;
      bit_i = 0;
      while (!m[bit_i]) bit_i++;
      vecs[k].first = 4'(bit_i);
    end

    #1 rst_n = 1'b0;
    #1;
    chk("reset_outputs", 32'({abcd_o, busy, done, pass, err_cnt, first_err_idx}), 32'd0);
    chk("reset_captured", 32'(captured), 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < 8; k++) begin
      unit_tt = vecs[k].tt;
      sweep($sformatf("vec%0d", k), 1'b0, vecs[k].cap, vecs[k].err, vecs[k].first, vecs[k].pas);
    end

    // Reset mid-sweep while abcd_o == 7
    begin
      int t;
      unit_tt = g;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      t = 0;
      while (abcd_o != 4'd7 && t < 200) begin @(posedge clk); #1; t++; end
      chk("rst_reach_abcd7", 32'(abcd_o), 32'd7);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_outputs", 32'({abcd_o, busy, done, pass, err_cnt, first_err_idx}), 32'd0);
      chk("rst_async_captured", 32'(captured), 32'd0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      sweep("after_rst", 1'b0, g, 5'd0, 4'd0, 1'b1);
    end

    // Start pulse mid-sweep must not queue another sweep
    unit_tt = g;
    sweep("mid_pulse", 1'b1, g, 5'd0, 4'd0, 1'b1);
    begin
      bit b_any;
      b_any = 1'b0;
      repeat (4) begin @(posedge clk); #1; b_any |= busy; end
      chk("mid_pulse_not_queued", 32'(b_any), 32'd0);
    end

    // start held high, unit with one cycle of F delay
    unit_dly = 1'b1;
    begin
      int lat;
      @(negedge clk); start = 1'b1;
      lat = 0;
      @(posedge clk); #1;
      while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
      chk("held_first_latency", 32'(lat), 32'(LAT));
      chk("held_first_pass", 32'(pass), 32'd1);
      @(posedge clk); #1;
      chk("held_idle_gap", 32'({busy, done}), 32'd0);
      @(posedge clk); #1;
      chk("held_reaccept", 32'(busy), 32'd1);
      lat = 0;
      while (!done && lat < 200) begin @(posedge clk); #1; lat++; end
      chk("held_second_latency", 32'(lat), 32'(LAT));
      chk("held_second_captured", 32'(captured), 32'(g));
      chk("held_second_pass", 32'(pass), 32'd1);
      start = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
